// File: rtl/alu_pkg.sv
// alu_pkg: function-select codes and FSM state type shared by iter_alu and its datapath
package alu_pkg;
   localparam logic [3:0] F_ADD   = 4'd0;
   localparam logic [3:0] F_AND   = 4'd1;
   localparam logic [3:0] F_OR    = 4'd2;
   localparam logic [3:0] F_XOR   = 4'd3;
   localparam logic [3:0] F_SUB   = 4'd4;
   localparam logic [3:0] F_SLT   = 4'd5;
   localparam logic [3:0] F_MULTU = 4'd6;
   localparam logic [3:0] F_DIVU  = 4'd7;
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: one-bit-per-step unsigned shift-add multiplier / restoring divider
// Ports: clk, reset; load captures a, b and div (1 = divide); step advances one iteration;
// res_hi/res_lo present the value the registers take on the next step ({hi,lo} product, or remainder/quotient).
module alu_muldiv #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);
   logic [WIDTH-1:0] hi_r, lo_r, op_r, diff;
   logic [WIDTH:0]   sum, rem_sh;
   logic             div_r, ge;
   // multiply: add multiplicand when multiplier lsb set, then shift {carry,hi,lo} right
   assign sum    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, op_r} : '0);
   // divide: shift next dividend bit into the partial remainder, subtract if it fits
   assign rem_sh = {hi_r, lo_r[WIDTH-1]};
   assign ge     = rem_sh >= {1'b0, op_r};
   assign diff   = rem_sh[WIDTH-1:0] - op_r;
   assign res_hi = div_r ? (ge ? diff : rem_sh[WIDTH-1:0]) : sum[WIDTH:1];
   assign res_lo = div_r ? {lo_r[WIDTH-2:0], ge} : {sum[0], lo_r[WIDTH-1:1]};
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r  <= '0;
         lo_r  <= '0;
         op_r  <= '0;
         div_r <= 1'b0;
      end else if (load) begin
         hi_r  <= '0;
         lo_r  <= a;
         op_r  <= b;
         div_r <= div;
      end else if (step) begin
         hi_r <= res_hi;
         lo_r <= res_lo;
      end
   end
endmodule

// File: rtl/iter_alu.sv
// iter_alu: ALU with single-cycle logic/arith ops and WIDTH-cycle iterative MULTU/DIVU
// Ports: clk, reset (sync, active-high); start/fsel/a/b request an op while busy=0;
// dout/hi result words, cout/zero/neg/ovf/divz flags, all held until the next done pulse; busy, done.
module iter_alu
   import alu_pkg::*;
#(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       fsel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] hi,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             divz,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   add, sub;
   logic [WIDTH-1:0] r_lo, r_hi, m_hi, m_lo;
   logic             add_v, sub_v, slt, bz, r_c, r_v, iter;
   assign add   = {1'b0, a} + {1'b0, b};
   assign sub   = {1'b0, a} - {1'b0, b};
   assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (add[WIDTH-1] != a[WIDTH-1]);
   assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub[WIDTH-1] != a[WIDTH-1]);
   // direct signed compare stays correct where a-b would overflow
   assign slt   = $signed(a) < $signed(b);
   assign bz    = b == '0;
   assign iter  = fsel == F_MULTU || (fsel == F_DIVU && !bz);
   // single-cycle result; DIVU only reaches this path with b=0
   assign r_lo = fsel == F_ADD ? add[WIDTH-1:0] :
                 fsel == F_AND ? a & b :
                 fsel == F_OR  ? a | b :
                 fsel == F_XOR ? a ^ b :
                 fsel == F_SUB ? sub[WIDTH-1:0] :
                 fsel == F_SLT ? {{(WIDTH-1){1'b0}}, slt} :
                 fsel == F_DIVU ? '1 : '0;
   assign r_hi = fsel == F_DIVU ? a : '0;
   assign r_c  = fsel == F_ADD ? add[WIDTH] : fsel == F_SUB && sub[WIDTH];
   assign r_v  = fsel == F_ADD ? add_v : fsel == F_SUB && sub_v;
   alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .load   (state == IDLE && start),
      .step   (state != IDLE),
      .div    (fsel == F_DIVU),
      .a      (a),
      .b      (b),
      .res_hi (m_hi),
      .res_lo (m_lo)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         dout  <= '0;
         hi    <= '0;
         cout  <= 1'b0;
         zero  <= 1'b0;
         neg   <= 1'b0;
         ovf   <= 1'b0;
         divz  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start && iter) begin
               state <= fsel == F_MULTU ? MUL : DIV;
               busy  <= 1'b1;
               cnt   <= '0;
            end else if (start) begin
               dout <= r_lo;
               hi   <= r_hi;
               cout <= r_c;
               zero <= r_lo == '0;
               neg  <= r_lo[WIDTH-1];
               ovf  <= r_v;
               divz <= fsel == F_DIVU;
               done <= 1'b1;
            end
         end else begin
            cnt <= cnt + 1'b1;
            // the final step's value is taken straight from the datapath's next-step outputs
            if (cnt == CW'(WIDTH - 1)) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               dout  <= m_lo;
               hi    <= m_hi;
               cout  <= 1'b0;
               divz  <= 1'b0;
               zero  <= state == MUL ? {m_hi, m_lo} == '0 : m_lo == '0;
               neg   <= state == DIV && m_lo[WIDTH-1];
               ovf   <= state == MUL && m_hi != '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed and randomized checks of iter_alu (WIDTH=32 and WIDTH=8) against an arithmetic model
module tb_iter_alu;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, start, start8;
   logic [3:0] fsel, fsel8;
   logic [31:0] a, b, dout, hi;
   logic [7:0] a8, b8, dout8, hi8;
   logic cout, zero, neg, ovf, divz, busy, done;
   logic cout8, zero8, neg8, ovf8, divz8, busy8, done8;
   int checks = 0, errors = 0;

   iter_alu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .fsel(fsel), .a(a), .b(b),
      .dout(dout), .hi(hi), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf),
      .divz(divz), .busy(busy), .done(done));

   iter_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .fsel(fsel8), .a(a8), .b(b8),
      .dout(dout8), .hi(hi8), .cout(cout8), .zero(zero8), .neg(neg8), .ovf(ovf8),
      .divz(divz8), .busy(busy8), .done(done8));

   typedef struct {
      logic [63:0] lo;
      logic [63:0] hi;
      logic [4:0]  fl;
      bit          multi;
   } exp_t;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: plain integer arithmetic on w-bit operands; flags packed {cout,zero,neg,ovf,divz}
   function automatic exp_t model(input int w, input logic [3:0] f, input longint unsigned x, input longint unsigned y);
      exp_t e;
      longint unsigned m = (64'd1 << w) - 1;
      longint lim = longint'(1) << (w - 1);
      longint sx = ((x >> (w - 1)) & 1) != 0 ? longint'(x) - (longint'(1) << w) : longint'(x);
      longint sy = ((y >> (w - 1)) & 1) != 0 ? longint'(y) - (longint'(1) << w) : longint'(y);
      longint s;
      longint unsigned r = 0, h = 0, p;
      bit c = 0, v = 0, dz = 0, z, n;
      e.multi = 0;
      case (f)
         4'd0: begin r = (x + y) & m; c = ((x + y) >> w) != 0; s = sx + sy; v = s >= lim || s < -lim; end
         4'd1: r = x & y;
         4'd2: r = x | y;
         4'd3: r = x ^ y;
         4'd4: begin r = (x - y) & m; c = x < y; s = sx - sy; v = s >= lim || s < -lim; end
         4'd5: r = sx < sy ? 1 : 0;
         4'd6: begin p = x * y; r = p & m; h = p >> w; e.multi = 1; end
         4'd7: if (y == 0) begin r = m; h = x; dz = 1; end
               else begin r = x / y; h = x % y; e.multi = 1; end
         default: ;
      endcase
      if (f == 4'd6) begin z = r == 0 && h == 0; n = 0; v = h != 0; end
      else begin z = r == 0; n = ((r >> (w - 1)) & 1) != 0; end
      e.lo = r;
      e.hi = h;
      e.fl = {c, z, n, v, dz};
      return e;
   endfunction

   // issue one op on the 32-bit unit; while busy, optionally pulse start and always scramble operands
   task automatic run(input string tag, input logic [3:0] f, input logic [31:0] x, input logic [31:0] y, input bit noise);
      exp_t e = model(32, f, x, y);
      int nb = 0;
      @(negedge clk);
      start = 1; fsel = f; a = x; b = y;
      @(negedge clk);
      for (int i = 0; i < 100 && !done; i++) begin
         if (busy) nb++;
         start = noise && busy && $urandom_range(1) == 1;
         a = $urandom; b = $urandom; fsel = 4'($urandom);
         @(negedge clk);
      end
      start = 0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busycyc"}, nb, e.multi ? 32 : 0);
      chk({tag, "_dout"}, dout, e.lo);
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_flags"}, {cout, zero, neg, ovf, divz}, e.fl);
   endtask

   initial begin
      exp_t pe;
      logic [31:0] x, y;
      logic [3:0] f;
      int nb, nd;
      reset = 1; start = 0; fsel = 0; a = 0; b = 0;
      start8 = 0; fsel8 = 0; a8 = 0; b8 = 0;
      repeat (2) @(negedge clk);
      chk("rst_outs", {dout, hi, cout, zero, neg, ovf, divz, busy, done}, 0);
      reset = 0;

      run("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 0);
      chk("add_ovf_exact", {dout, cout, zero, neg, ovf}, {32'h80000000, 4'b0011});
      run("sub_neg", 4'd4, 32'h0, 32'h1, 0);
      chk("sub_neg_exact", {dout, cout, ovf}, {32'hFFFFFFFF, 2'b10});
      run("slt_lt", 4'd5, 32'h80000000, 32'h7FFFFFFF, 0);
      chk("slt_lt_exact", dout, 1);
      run("slt_ge", 4'd5, 32'h7FFFFFFF, 32'h80000000, 0);
      chk("slt_ge_zero", {dout, zero}, {32'h0, 1'b1});
      run("mul_max", 4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
      chk("mul_max_exact", {hi, dout, ovf}, {32'hFFFFFFFE, 32'h1, 1'b1});
      run("div_100_7", 4'd7, 32'd100, 32'd7, 1);
      chk("div_exact", {dout, hi}, {32'd14, 32'd2});
      run("div_by0", 4'd7, 32'd5, 32'd0, 0);
      chk("div_by0_exact", {divz, dout, hi}, {1'b1, 32'hFFFFFFFF, 32'd5});
      run("dflt", 4'd9, 32'h1234, 32'h5678, 0);

      // results hold while idle, no stray done
      run("hold", 4'd3, 32'hA5A5A5A5, 32'h0F0F0F0F, 0);
      repeat (3) @(negedge clk);
      chk("hold_dout", dout, 32'hAAAAAAAA);
      chk("hold_nodone", done, 0);

      for (int i = 0; i < 24; i++) begin
         f = 4'($urandom_range(15));
         x = $urandom;
         y = $urandom_range(3) == 0 ? 32'h0 : $urandom;
         if (i % 5 == 0) y = y >> $urandom_range(31);
         run($sformatf("rnd%0d_f%0d", i, f), f, x, y, $urandom_range(1) == 1);
      end

      // reset mid-DIVU aborts; simultaneous start is ignored
      @(negedge clk);
      start = 1; fsel = 4'd7; a = 100; b = 7;
      @(negedge clk);
      start = 0;
      nb = 0;
      for (int i = 0; i < 40 && nb < 10; i++) begin
         if (busy) nb++;
         if (nb < 10) @(negedge clk);
      end
      reset = 1; start = 1; fsel = 4'd0; a = 2; b = 3;
      @(negedge clk);
      chk("abort_outs", {dout, hi, cout, zero, neg, ovf, divz, busy, done}, 0);
      reset = 0;
      @(negedge clk);
      start = 0;
      chk("abort_add_done", done, 1);
      chk("abort_add_dout", dout, 5);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort_no_done", nd, 0);

      // WIDTH=8 multiply
      start8 = 1; fsel8 = 4'd6; a8 = 8'h10; b8 = 8'h10;
      @(negedge clk);
      start8 = 0; a8 = 8'hFF; b8 = 8'hFF;
      nb = 0;
      for (int i = 0; i < 40 && !done8; i++) begin
         if (busy8) nb++;
         @(negedge clk);
      end
      chk("m8_done", done8, 1);
      chk("m8_busycyc", nb, 8);
      chk("m8_res", {hi8, dout8}, 16'h0100);
      chk("m8_flags", {cout8, zero8, neg8, ovf8, divz8}, 5'b00010);

      // WIDTH=8 back-to-back single-cycle stream: one done per clock
      @(negedge clk);
      for (int i = 0; i <= 12; i++) begin
         if (i > 0) begin
            chk($sformatf("b2b%0d_done", i), done8, 1);
            chk($sformatf("b2b%0d_dout", i), dout8, pe.lo);
            chk($sformatf("b2b%0d_flags", i), {cout8, zero8, neg8, ovf8, divz8}, pe.fl);
         end
         if (i < 12) begin
            start8 = 1;
            fsel8 = 4'($urandom_range(i < 6 ? 1 : 0, i < 6 ? 3 : 5));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            pe = model(8, fsel8, a8, b8);
         end else start8 = 0;
         @(negedge clk);
      end
      chk("b2b_end_nodone", done8, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
